frame_ctrl: RTL and testbench
=============================

Name: frame_ctrl

Overview:
- Register-window controller directly upstream of the 16x16 windowed register file.
- Holds the frame pointer (FP) and a stack of frame offsets.
- Turns decoded CALL/RTN requests and 3-bit window register numbers into 4-bit physical addresses and the FP-move controls the register file consumes.
- The frame stack grows downward: CALL lowers FP, RTN raises it.

Parameters:
- RESET_FP, 8, FP value after reset; must be <= 8 so FP+7 stays <= 15.
- DEPTH, 4, number of frame-offset stack entries; power of 2, max 8.

Ports:
- Clock  in  1  system clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-high reset.
- Call  in  1  decoded CALL request; sampled only in IDLE.
- Rtn  in  1  decoded RTN request; sampled only in IDLE.
- Frame_Off  in  3  CALL frame offset I; 0 is illegal.
- Win_Rd, Win_Rs, Win_Rm  in  3 each  window register numbers from decode.
- Rd_Wen_In  in  1  decode's Rd write enable.
- Rs_Wen_In  in  1  decode's Rs write enable.
- Rd_Addr, Rs_Addr, Rm_Addr  out  4 each  physical addresses, FP + window number, mod 16.
- Actual_Rd, Actual_Rm  out  3 each  window numbers passed to the register file.
- Actual_Rs  out  3  window number, or the move offset while FP_move=1.
- Rd_Wen, Rs_Wen  out  1 each  gated write enables.
- New_FP  out  4  FP after the current move.
- FP_move  out  1  FP changes at this edge.
- FP_push_up  out  1  1 for CALL, 0 for RTN.
- Busy  out  1  decode must hold its instruction.
- Fault  out  1  sticky frame fault.
- FP  out  4  current frame pointer, registered.
- Depth  out  4  current stack occupancy, 0..DEPTH.

Behaviour:
- Reset values (asynchronous): FP=RESET_FP, Depth=0, stack entries 0, state IDLE, Fault=0. Combinational outputs follow with all inputs 0, e.g. New_FP=RESET_FP, FP_move=0, Busy=0.
- Address arithmetic:
  - Physical address = FP + {1'b0, window number}, 4-bit, wrap mod 16.
  - Addresses always use the current (old) FP, including in a move cycle.
- States: IDLE, SETTLE, FAULT.
- IDLE, Call=1 and Rtn=0 (legal CALL):
  - Legal only if Frame_Off != 0, Frame_Off <= FP and Depth < DEPTH.
  - Same cycle, combinational: FP_move=1, FP_push_up=1, New_FP=FP-Frame_Off, Actual_Rs=Frame_Off, Rs_Wen=0, Rd_Wen=Rd_Wen_In.
  - At the edge: push Frame_Off, Depth+1, FP<=New_FP, go to SETTLE.
- IDLE, Rtn=1 and Call=0 (legal RTN):
  - Legal only if Depth > 0.
  - Same cycle, combinational: I = stack top, FP_move=1, FP_push_up=0, New_FP=FP+I, Actual_Rs=I, Rs_Wen=0, Rd_Wen=Rd_Wen_In.
  - At the edge: pop, Depth-1, FP<=New_FP, go to SETTLE.
- IDLE, illegal request:
  - Covers: Call and Rtn both 1; CALL with Frame_Off=0, Frame_Off>FP or Depth=DEPTH; RTN with Depth=0.
  - No move; Rd_Wen=Rs_Wen=0; next state FAULT. FP and stack unchanged.
- IDLE, no request: FP_move=0, New_FP=FP, enables and window numbers pass through.
- SETTLE (exactly 1 cycle):
  - Busy=1, FP_move=0, write enables forced 0; Call/Rtn ignored.
  - Next state IDLE. Back-to-back frame ops are therefore >= 2 cycles apart.
- FAULT:
  - Fault=1, Busy=1, all write enables 0, FP_move=0.
  - Left only by Reset.
- Busy=0 in IDLE; a request is consumed in its IDLE cycle, so no extra hold is needed there.
- Reset mid-SETTLE or mid-FAULT: immediate return to reset values. A push whose edge coincides with Reset assertion is lost.
- Invariants: FP stays in 0..8; Depth never exceeds DEPTH nor goes below 0.

Test Plan:
- Reset, idle, Win_Rd=3, Rd_Wen_In=1 -> Rd_Addr=11, Rd_Wen=1, FP_move=0, New_FP=8, Depth=0.
- IDLE, Call=1, Frame_Off=4, Win_Rd=2, Rd_Wen_In=1 -> that cycle:
  - FP_move=1, FP_push_up=1, New_FP=4, Actual_Rs=4, Rd_Addr=10.
  - Next cycle: FP=4, Depth=1, Busy=1, Rd_Wen=0.
  - Following cycle: Busy=0.
- After the CALL above, Rtn=1 -> FP_move=1, FP_push_up=0, New_FP=8, Actual_Rs=4; then FP=8, Depth=0, one Busy cycle.
- From FP=8, four CALLs of offset 2 (each followed by SETTLE) -> FP=0, Depth=4. Then:
  - Fifth CALL, offset 1 -> FAULT: Fault=1, Busy=1, FP=0 unchanged.
  - Reset -> FP=8, Fault=0.
- RTN at Depth=0 -> FAULT, FP=8 unchanged. Call=Rtn=1 in IDLE -> FAULT. CALL with Frame_Off=0 -> FAULT.
- Call asserted during SETTLE -> ignored (Depth unchanged). Reset asserted during SETTLE -> immediate FP=RESET_FP, Depth=0, Busy=0.

Source files
------------

// File: rtl/frame_ctrl.sv
// Register-window frame controller: frame pointer, frame-offset stack,
// window-to-physical address mapping and FP-move controls for the regfile.
//
// Ports:
//   Clock, Reset          posedge clock, async active-high reset
//   Call, Rtn, Frame_Off  decoded frame requests (sampled in IDLE only)
//   Win_Rd/Rs/Rm          window register numbers from decode
//   Rd_Wen_In, Rs_Wen_In  decode write enables
//   Rd/Rs/Rm_Addr         physical addresses (old FP + window, mod 16)
//   Actual_Rd/Rs/Rm       window numbers to regfile (Rs = offset on a move)
//   Rd_Wen, Rs_Wen        gated write enables
//   New_FP, FP_move       FP after this edge and move strobe
//   FP_push_up            1 for CALL, 0 for RTN
//   Busy, Fault           hold request / sticky frame fault
//   FP, Depth             registered frame pointer and stack occupancy
module frame_ctrl #(
  parameter logic [3:0] RESET_FP = 4'd8,
  parameter int         DEPTH    = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Call,
  input  logic       Rtn,
  input  logic [2:0] Frame_Off,
  input  logic [2:0] Win_Rd,
  input  logic [2:0] Win_Rs,
  input  logic [2:0] Win_Rm,
  input  logic       Rd_Wen_In,
  input  logic       Rs_Wen_In,
  output logic [3:0] Rd_Addr,
  output logic [3:0] Rs_Addr,
  output logic [3:0] Rm_Addr,
  output logic [2:0] Actual_Rd,
  output logic [2:0] Actual_Rs,
  output logic [2:0] Actual_Rm,
  output logic       Rd_Wen,
  output logic       Rs_Wen,
  output logic [3:0] New_FP,
  output logic       FP_move,
  output logic       FP_push_up,
  output logic       Busy,
  output logic       Fault,
  output logic [3:0] FP,
  output logic [3:0] Depth
);

  localparam int         AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DMAX = 4'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_FAULT
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] fp_q, fp_d;
  logic [3:0] depth_q, depth_d;
  logic [2:0] stack_q [DEPTH];
  logic [2:0] stack_d [DEPTH];

  logic [AW-1:0] push_idx;
  logic [AW-1:0] top_idx;
  logic [2:0]    top_off;
  logic          call_ok;
  logic          rtn_ok;

  // Push slot is the current depth; top of stack sits one below it.
  assign push_idx = depth_q[AW-1:0];
  assign top_idx  = AW'(depth_q - 4'd1);
  assign top_off  = stack_q[top_idx];

  assign call_ok = Call && !Rtn
                && (Frame_Off != 3'd0)
                && ({1'b0, Frame_Off} <= fp_q)
                && (depth_q < DMAX);
  assign rtn_ok  = Rtn && !Call && (depth_q != 4'd0);

  // Addresses always use the old FP, even in a move cycle.
  assign Rd_Addr   = fp_q + {1'b0, Win_Rd};
  assign Rs_Addr   = fp_q + {1'b0, Win_Rs};
  assign Rm_Addr   = fp_q + {1'b0, Win_Rm};
  assign Actual_Rd = Win_Rd;
  assign Actual_Rm = Win_Rm;
  assign FP        = fp_q;
  assign Depth     = depth_q;
  assign Fault     = (state_q == S_FAULT);

  always_comb begin
    state_d    = state_q;
    fp_d       = fp_q;
    depth_d    = depth_q;
    stack_d    = stack_q;
    New_FP     = fp_q;
    FP_move    = 1'b0;
    FP_push_up = 1'b0;
    Actual_Rs  = Win_Rs;
    Rd_Wen     = 1'b0;
    Rs_Wen     = 1'b0;
    Busy       = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        Busy = 1'b0;
        if (call_ok) begin
          FP_move           = 1'b1;
          FP_push_up        = 1'b1;
          New_FP            = fp_q - {1'b0, Frame_Off};
          Actual_Rs         = Frame_Off;
          Rd_Wen            = Rd_Wen_In;
          fp_d              = New_FP;
          depth_d           = depth_q + 4'd1;
          stack_d[push_idx] = Frame_Off;
          state_d           = S_SETTLE;
        end else if (rtn_ok) begin
          FP_move   = 1'b1;
          New_FP    = fp_q + {1'b0, top_off};
          Actual_Rs = top_off;
          Rd_Wen    = Rd_Wen_In;
          fp_d      = New_FP;
          depth_d   = depth_q - 4'd1;
          state_d   = S_SETTLE;
        end else if (Call || Rtn) begin
          state_d = S_FAULT;
        end else begin
          Rd_Wen = Rd_Wen_In;
          Rs_Wen = Rs_Wen_In;
        end
      end
      S_SETTLE: state_d = S_IDLE;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      fp_q    <= RESET_FP;
      depth_q <= 4'd0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= 3'd0;
    end else begin
      state_q <= state_d;
      fp_q    <= fp_d;
      depth_q <= depth_d;
      stack_q <= stack_d;
    end
  end

endmodule

// File: tb/tb_frame_ctrl.sv
// Self-checking bench for frame_ctrl: directed scenarios plus
// randomized traffic against a queue-based frame model.
module tb_frame_ctrl;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Call = 1'b0, Rtn = 1'b0;
  logic [2:0] Frame_Off = '0;
  logic [2:0] Win_Rd = '0, Win_Rs = '0, Win_Rm = '0;
  logic       Rd_Wen_In = 1'b0, Rs_Wen_In = 1'b0;
  logic [3:0] Rd_Addr, Rs_Addr, Rm_Addr;
  logic [2:0] Actual_Rd, Actual_Rs, Actual_Rm;
  logic       Rd_Wen, Rs_Wen;
  logic [3:0] New_FP;
  logic       FP_move, FP_push_up, Busy, Fault;
  logic [3:0] FP, Depth;

  int n_chk = 0;
  int n_fail = 0;

  frame_ctrl dut (
    .Clock(Clock), .Reset(Reset),
    .Call(Call), .Rtn(Rtn), .Frame_Off(Frame_Off),
    .Win_Rd(Win_Rd), .Win_Rs(Win_Rs), .Win_Rm(Win_Rm),
    .Rd_Wen_In(Rd_Wen_In), .Rs_Wen_In(Rs_Wen_In),
    .Rd_Addr(Rd_Addr), .Rs_Addr(Rs_Addr), .Rm_Addr(Rm_Addr),
    .Actual_Rd(Actual_Rd), .Actual_Rs(Actual_Rs),
    .Actual_Rm(Actual_Rm),
    .Rd_Wen(Rd_Wen), .Rs_Wen(Rs_Wen),
    .New_FP(New_FP), .FP_move(FP_move), .FP_push_up(FP_push_up),
    .Busy(Busy), .Fault(Fault), .FP(FP), .Depth(Depth)
  );

  always #5 Clock = ~Clock;

  task automatic clear_in();
    Call = 0; Rtn = 0; Frame_Off = 0;
    Win_Rd = 0; Win_Rs = 0; Win_Rm = 0;
    Rd_Wen_In = 0; Rs_Wen_In = 0;
  endtask

  task automatic apply_reset();
    @(negedge Clock);
    clear_in();
    Reset = 1;
    #2 Reset = 0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    @(negedge Clock);
    clear_in();
    Reset = 1;
    #1;
    n_chk++;
    if (FP !== 4'd8 || Depth !== 4'd0 || Busy !== 1'b0
        || Fault !== 1'b0 || FP_move !== 1'b0 || New_FP !== 4'd8) begin
      n_fail++;
      $display("FAIL reset_vals got FP=%0d D=%0d B=%b F=%b M=%b N=%0d",
               FP, Depth, Busy, Fault, FP_move, New_FP);
    end
    #1 Reset = 0;
    Win_Rd = 3; Rd_Wen_In = 1;
    #1;
    n_chk++;
    if (Rd_Addr !== 4'd11 || Rd_Wen !== 1'b1 || FP_move !== 1'b0
        || New_FP !== 4'd8 || Depth !== 4'd0) begin
      n_fail++;
      $display("FAIL idle_pass got A=%0d W=%b M=%b N=%0d D=%0d want 11 1 0 8 0",
               Rd_Addr, Rd_Wen, FP_move, New_FP, Depth);
    end
  endtask

  task automatic test_call_rtn();
    apply_reset();
    Call = 1; Frame_Off = 4; Win_Rd = 2; Rd_Wen_In = 1;
    #1;
    n_chk++;
    if (FP_move !== 1 || FP_push_up !== 1 || New_FP !== 4'd4
        || Actual_Rs !== 3'd4 || Rd_Addr !== 4'd10 || Rs_Wen !== 0
        || Rd_Wen !== 1) begin
      n_fail++;
      $display("FAIL call_comb got M=%b U=%b N=%0d Rs=%0d A=%0d",
               FP_move, FP_push_up, New_FP, Actual_Rs, Rd_Addr);
    end
    tick();
    Call = 0;
    #1;
    n_chk++;
    if (FP !== 4'd4 || Depth !== 4'd1 || Busy !== 1 || Rd_Wen !== 0
        || FP_move !== 0) begin
      n_fail++;
      $display("FAIL call_settle got FP=%0d D=%0d B=%b W=%b want 4 1 1 0",
               FP, Depth, Busy, Rd_Wen);
    end
    tick();
    n_chk++;
    if (Busy !== 0) begin
      n_fail++;
      $display("FAIL call_idle got Busy=%b want 0", Busy);
    end
    Rtn = 1;
    #1;
    n_chk++;
    if (FP_move !== 1 || FP_push_up !== 0 || New_FP !== 4'd8
        || Actual_Rs !== 3'd4) begin
      n_fail++;
      $display("FAIL rtn_comb got M=%b U=%b N=%0d Rs=%0d want 1 0 8 4",
               FP_move, FP_push_up, New_FP, Actual_Rs);
    end
    tick();
    Rtn = 0;
    #1;
    n_chk++;
    if (FP !== 4'd8 || Depth !== 4'd0 || Busy !== 1) begin
      n_fail++;
      $display("FAIL rtn_settle got FP=%0d D=%0d B=%b want 8 0 1",
               FP, Depth, Busy);
    end
    tick();
    n_chk++;
    if (Busy !== 0) begin
      n_fail++;
      $display("FAIL rtn_idle got Busy=%b want 0", Busy);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      Call = 1; Frame_Off = 2;
      tick();
      Call = 0;
      tick();
    end
    n_chk++;
    if (FP !== 4'd0 || Depth !== 4'd4) begin
      n_fail++;
      $display("FAIL full_stack got FP=%0d D=%0d want 0 4", FP, Depth);
    end
    Call = 1; Frame_Off = 1; Rd_Wen_In = 1;
    tick();
    Call = 0;
    #1;
    n_chk++;
    if (Fault !== 1 || Busy !== 1 || FP !== 4'd0 || Rd_Wen !== 0) begin
      n_fail++;
      $display("FAIL overflow got F=%b B=%b FP=%0d W=%b want 1 1 0 0",
               Fault, Busy, FP, Rd_Wen);
    end
    Reset = 1;
    #1;
    n_chk++;
    if (FP !== 4'd8 || Fault !== 0 || Depth !== 4'd0) begin
      n_fail++;
      $display("FAIL fault_reset got FP=%0d F=%b D=%0d want 8 0 0",
               FP, Fault, Depth);
    end
    Reset = 0;
  endtask

  task automatic test_illegal();
    for (int k = 0; k < 3; k++) begin
      apply_reset();
      Rd_Wen_In = 1; Rs_Wen_In = 1;
      case (k)
        0: Rtn = 1;
        1: begin Call = 1; Rtn = 1; Frame_Off = 2; end
        default: begin Call = 1; Frame_Off = 0; end
      endcase
      #1;
      n_chk++;
      if (FP_move !== 0 || Rd_Wen !== 0 || Rs_Wen !== 0 || Busy !== 0) begin
        n_fail++;
        $display("FAIL illegal_comb%0d got M=%b Wd=%b Ws=%b B=%b",
                 k, FP_move, Rd_Wen, Rs_Wen, Busy);
      end
      tick();
      clear_in();
      #1;
      n_chk++;
      if (Fault !== 1 || Busy !== 1 || FP !== 4'd8 || Depth !== 4'd0) begin
        n_fail++;
        $display("FAIL illegal_state%0d got F=%b B=%b FP=%0d D=%0d",
                 k, Fault, Busy, FP, Depth);
      end
    end
  endtask

  task automatic test_settle();
    apply_reset();
    Call = 1; Frame_Off = 3;
    tick();
    #1;
    n_chk++;
    if (FP_move !== 0 || Busy !== 1) begin
      n_fail++;
      $display("FAIL settle_hold got M=%b B=%b want 0 1", FP_move, Busy);
    end
    tick();
    Call = 0;
    #1;
    n_chk++;
    if (Depth !== 4'd1 || FP !== 4'd5) begin
      n_fail++;
      $display("FAIL settle_ignore got D=%0d FP=%0d want 1 5", Depth, FP);
    end
    Call = 1; Frame_Off = 1;
    tick();
    Call = 0;
    Reset = 1;
    #1;
    n_chk++;
    if (FP !== 4'd8 || Depth !== 4'd0 || Busy !== 0) begin
      n_fail++;
      $display("FAIL settle_reset got FP=%0d D=%0d B=%b want 8 0 0",
               FP, Depth, Busy);
    end
    Reset = 0;
  endtask

  task automatic test_random();
    int   fp;
    int   mode;
    int   stk[$];
    int   off;
    bit   mv, up, nxt_fault;
    logic [45:0] got, exp;
    logic [3:0]  e_nfp;
    logic [2:0]  e_rs;
    logic        e_wd, e_ws;
    apply_reset();
    fp = 8; mode = 0; stk = {};
    for (int c = 0; c < 600; c++) begin
      if (($urandom % 60 == 0) || (mode == 2 && $urandom % 4 == 0)) begin
        apply_reset();
        fp = 8; mode = 0; stk = {};
      end
      Call      = ($urandom % 3 == 0);
      Rtn       = ($urandom % 3 == 0);
      Frame_Off = 3'($urandom_range(0, 7));
      if ($urandom % 4 != 0 && fp > 0)
        Frame_Off = 3'($urandom_range(1, (fp > 7) ? 7 : fp));
      Win_Rd    = 3'($urandom);
      Win_Rs    = 3'($urandom);
      Win_Rm    = 3'($urandom);
      Rd_Wen_In = 1'($urandom);
      Rs_Wen_In = 1'($urandom);
      off       = int'(Frame_Off);
      mv = 0; up = 0; nxt_fault = 0;
      e_nfp = 4'(fp); e_rs = Win_Rs; e_wd = 0; e_ws = 0;
      if (mode == 0) begin
        if (Call && !Rtn && off != 0 && off <= fp && stk.size() < 4) begin
          mv = 1; up = 1;
          e_nfp = 4'(fp - off); e_rs = Frame_Off; e_wd = Rd_Wen_In;
        end else if (Rtn && !Call && stk.size() > 0) begin
          mv = 1;
          e_nfp = 4'(fp + stk[$]); e_rs = 3'(stk[$]); e_wd = Rd_Wen_In;
        end else if (Call || Rtn) begin
          nxt_fault = 1;
        end else begin
          e_wd = Rd_Wen_In; e_ws = Rs_Wen_In;
        end
      end
      #1;
      got = {Rd_Addr, Rs_Addr, Rm_Addr, Actual_Rd, Actual_Rs, Actual_Rm,
             Rd_Wen, Rs_Wen, New_FP, FP_move, Busy, Fault, FP, Depth};
      exp = {4'(fp + int'(Win_Rd)), 4'(fp + int'(Win_Rs)),
             4'(fp + int'(Win_Rm)), Win_Rd, e_rs, Win_Rm,
             e_wd, e_ws, e_nfp, mv, (mode != 0), (mode == 2),
             4'(fp), 4'(stk.size())};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rand_outs cyc=%0d got=%h want=%h", c, got, exp);
      end
      if (mv) begin
        n_chk++;
        if (FP_push_up !== up) begin
          n_fail++;
          $display("FAIL rand_pushup cyc=%0d got=%b want=%b",
                   c, FP_push_up, up);
        end
      end
      tick();
      if (mv) begin
        if (up) stk.push_back(off);
        else void'(stk.pop_back());
        fp = int'(e_nfp);
        mode = 1;
      end else if (nxt_fault) begin
        mode = 2;
      end else if (mode == 1) begin
        mode = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_call_rtn();
    test_overflow();
    test_illegal();
    test_settle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
